v810_bus_arb: RTL

//  Two-requester arbiter in front of v810_mem's single execution-data port.

---
 rtl/v810_bus_arb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/v810_bus_arb.sv
// Two-requester arbiter (IF fetch / EX data) in front of the single mem-unit data port.
// Optional build macro V810_ARB_RR_EN: round-robin pick instead of EX priority with burst cap.
module v810_bus_arb #(
  parameter int EX_MAX_BURST = 4
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] IF_A,
  input  logic        IF_REQ,
  output logic [31:0] IF_D,
  output logic        IF_ACK,
  input  logic [31:0] EX_A,
  input  logic [31:0] EX_D_O,
  input  logic [1:0]  EX_BC,
  input  logic [3:0]  EX_BE,
  input  logic        EX_WR,
  input  logic        EX_REQ,
  output logic [31:0] EX_D_I,
  output logic        EX_ACK,
  output logic [31:0] EDA,
  output logic [31:0] EDD_O,
  output logic [1:0]  EDBC,
  output logic [3:0]  EDBE,
  output logic        EDWR,
  output logic        EDREQ,
  input  logic [31:0] EDD_I,
  input  logic        EDACK
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_EX   = 2'd2
  } own_t;

  own_t own_reg;
  own_t pick;
  own_t sel;

`ifdef V810_ARB_RR_EN
  logic last_ex_reg;
`else
  localparam int RUN_W = $clog2(EX_MAX_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(EX_MAX_BURST);
  logic [RUN_W-1:0] ex_run_reg;
`endif

  logic unused_if_a_lsbs;
  assign unused_if_a_lsbs = ^IF_A[1:0];

  always_comb begin
    pick = OWN_NONE;
    if (EX_REQ && IF_REQ) begin
`ifdef V810_ARB_RR_EN
      pick = last_ex_reg ? OWN_IF : OWN_EX;
`else
      // IF gets one grant after EX has won EX_MAX_BURST times in a row
      pick = (ex_run_reg == RUN_MAX) ? OWN_IF : OWN_EX;
`endif
    end else if (EX_REQ) begin
      pick = OWN_EX;
    end else if (IF_REQ) begin
      pick = OWN_IF;
    end
  end

  assign sel = (own_reg != OWN_NONE) ? own_reg : pick;

  always_comb begin
    EDA   = 32'h0;
    EDD_O = 32'h0;
    EDBC  = 2'd0;
    EDBE  = 4'h0;
    EDWR  = 1'b0;
    case (sel)
      OWN_IF: begin
        EDA  = {IF_A[31:2], 2'b00};
        EDBC = 2'd3;
        EDBE = 4'hF;
      end
      OWN_EX: begin
        EDA   = EX_A;
        EDD_O = EX_D_O;
        EDBC  = EX_BC;
        EDBE  = EX_BE;
        EDWR  = EX_WR;
      end
      default: ;
    endcase
  end

  assign EDREQ = RESn & (((sel == OWN_IF) & IF_REQ) | ((sel == OWN_EX) & EX_REQ));
  // Acks are masked while in reset so an aborted access never completes
  assign IF_ACK = RESn & EDACK & (sel == OWN_IF);
  assign EX_ACK = RESn & EDACK & (sel == OWN_EX);
  assign IF_D   = EDD_I;
  assign EX_D_I = EDD_I;

  always_ff @(posedge CLK) begin
    if (CE) begin
      if (!RESn) begin
        own_reg <= OWN_NONE;
`ifdef V810_ARB_RR_EN
        last_ex_reg <= 1'b0;
`else
        ex_run_reg <= '0;
`endif
      end else begin
        // Release in the ACK cycle so the next pick is combinational
        if (EDACK) begin
          own_reg <= OWN_NONE;
        end else if (EDREQ) begin
          own_reg <= sel;
        end
`ifdef V810_ARB_RR_EN
        if (EDACK && sel != OWN_NONE) begin
          last_ex_reg <= (sel == OWN_EX);
        end
`else
        if (!IF_REQ || (EDACK && sel == OWN_IF)) begin
          ex_run_reg <= '0;
        end else if (EDACK && sel == OWN_EX && ex_run_reg != RUN_MAX) begin
          ex_run_reg <= ex_run_reg + 1'b1;
        end
`endif
      end
    end
  end

endmodule
